// File: rtl/debug_hub.sv
// debug_hub: debug-bus endpoint that controls NUM_CORES cores.
// It handles halt, resume, single-step and status commands, plus register
// reads and writes on halted cores. Each command has a timeout and can report
// an error.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   bus_addr          debug-bus target address
//   bus_start         command strobe
//   bus_wdata         command word: [7:0] op, [15:8] core, [15+REG_AW:16] reg,
//                     [63:32] write data
//   bus_rdata         response word: [0] ok, [1] error, [2] timeout,
//                     [63:32] value
//   bus_drive         combinational address match, enables shared-bus drivers
//   bus_accepted      one-cycle pulse, command latched
//   bus_available     one-cycle pulse, bus_rdata holds a new response
//   hlt_req/hlt_state per-core halt request / halted indication
//   step_req          per-core one-cycle step pulse
//   step_done         per-core pulse, stepped instruction retired
//   reg_*             register-file debug port (req/ack handshake)
module debug_hub #(
  parameter logic [7:0] BUS_ADDR  = 8'd3,
  parameter int         DATA_W    = 64,
  parameter int         NUM_CORES = 2,
  parameter int         REG_AW    = 4,
  parameter int         TIMEOUT   = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           bus_addr,
  input  logic                 bus_start,
  input  logic [DATA_W-1:0]    bus_wdata,
  output logic [DATA_W-1:0]    bus_rdata,
  output logic                 bus_drive,
  output logic                 bus_accepted,
  output logic                 bus_available,
  output logic [NUM_CORES-1:0] hlt_req,
  input  logic [NUM_CORES-1:0] hlt_state,
  output logic [NUM_CORES-1:0] step_req,
  input  logic [NUM_CORES-1:0] step_done,
  output logic                 reg_req,
  output logic [7:0]           reg_core,
  output logic [REG_AW-1:0]    reg_addr,
  output logic                 reg_we,
  output logic [31:0]          reg_wdata,
  input  logic                 reg_ack,
  input  logic [31:0]          reg_rdata
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  localparam logic [7:0] OP_STATUS = 8'd0;
  localparam logic [7:0] OP_HALT   = 8'd1;
  localparam logic [7:0] OP_RESUME = 8'd2;
  localparam logic [7:0] OP_STEP   = 8'd3;
  localparam logic [7:0] OP_REG_RD = 8'd4;
  localparam logic [7:0] OP_REG_WR = 8'd5;

  state_t              state_reg;
  logic [7:0]          op_reg;
  logic [7:0]          core_reg;
  logic [REG_AW-1:0]   regidx_reg;
  logic [31:0]         wdata_reg;
  logic [15:0]         cnt_reg;
  logic                resp_phase_reg;
  logic [DATA_W-1:0]   resp_reg;

  logic [NUM_CORES-1:0] core_oh;
  logic                 core_ok;
  logic                 sel_halted;
  logic                 sel_step_done;
  logic                 wait_met;
  logic [31:0]          status_value;
  logic                 unused_bits;

  assign bus_drive   = (bus_addr == BUS_ADDR);
  // Only the low command fields are decoded.
  assign unused_bits = ^bus_wdata;

  // One-hot decode of the target core. Out-of-range indices decode to zero
  // and are rejected in EXEC.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_dec
    assign core_oh[gi] = (core_reg == 8'(gi));
  end

  // Halted vector padded with zeros (or truncated) to the 32-bit value field.
  for (genvar gi = 0; gi < 32; gi++) begin : g_status
    if (gi < NUM_CORES) begin : g_bit
      assign status_value[gi] = hlt_state[gi];
    end else begin : g_zero
      assign status_value[gi] = 1'b0;
    end
  end

  assign core_ok       = ({1'b0, core_reg} < 9'(NUM_CORES));
  assign sel_halted    = |(hlt_state & core_oh);
  assign sel_step_done = |(step_done & core_oh);

  always_comb begin
    wait_met = 1'b0;
    case (op_reg)
      OP_HALT:              wait_met = sel_halted;
      OP_RESUME:            wait_met = !sel_halted;
      OP_STEP:              wait_met = sel_step_done;
      OP_REG_RD, OP_REG_WR: wait_met = reg_ack;
      default:              wait_met = 1'b0;
    endcase
  end

  function automatic logic [DATA_W-1:0] make_resp(input logic ok, input logic err,
                                                  input logic tmo, input logic [31:0] value);
    logic [DATA_W-1:0] r;
    r        = '0;
    r[0]     = ok;
    r[1]     = err;
    r[2]     = tmo;
    r[63:32] = value;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      op_reg         <= '0;
      core_reg       <= '0;
      regidx_reg     <= '0;
      wdata_reg      <= '0;
      cnt_reg        <= '0;
      resp_phase_reg <= 1'b0;
      resp_reg       <= '0;
      bus_rdata      <= '0;
      bus_accepted   <= 1'b0;
      bus_available  <= 1'b0;
      hlt_req        <= '1;
      step_req       <= '0;
      reg_req        <= 1'b0;
      reg_core       <= '0;
      reg_addr       <= '0;
      reg_we         <= 1'b0;
      reg_wdata      <= '0;
    end else begin
      bus_accepted  <= 1'b0;
      bus_available <= 1'b0;
      step_req      <= '0;
      case (state_reg)
        IDLE: begin
          if (bus_drive && bus_start) begin
            op_reg       <= bus_wdata[7:0];
            core_reg     <= bus_wdata[15:8];
            regidx_reg   <= bus_wdata[15+REG_AW:16];
            wdata_reg    <= bus_wdata[63:32];
            bus_accepted <= 1'b1;
            state_reg    <= EXEC;
          end
        end
        EXEC: begin
          cnt_reg        <= '0;
          resp_phase_reg <= 1'b0;
          if (!core_ok || op_reg > OP_REG_WR) begin
            resp_reg  <= make_resp(1'b0, 1'b1, 1'b0, 32'd0);
            state_reg <= RESP;
          end else begin
            case (op_reg)
              OP_STATUS: begin
                resp_reg  <= make_resp(1'b1, 1'b0, 1'b0, status_value);
                state_reg <= RESP;
              end
              OP_HALT: begin
                hlt_req   <= hlt_req | core_oh;
                state_reg <= WAIT;
              end
              OP_RESUME: begin
                hlt_req   <= hlt_req & ~core_oh;
                state_reg <= WAIT;
              end
              OP_STEP: begin
                if (sel_halted) begin
                  hlt_req   <= hlt_req | core_oh;
                  step_req  <= core_oh;
                  state_reg <= WAIT;
                end else begin
                  resp_reg  <= make_resp(1'b0, 1'b1, 1'b0, 32'd0);
                  state_reg <= RESP;
                end
              end
              default: begin  // REG_RD / REG_WR
                if (sel_halted) begin
                  reg_req   <= 1'b1;
                  reg_core  <= core_reg;
                  reg_addr  <= regidx_reg;
                  reg_we    <= (op_reg == OP_REG_WR);
                  reg_wdata <= wdata_reg;
                  state_reg <= WAIT;
                end else begin
                  resp_reg  <= make_resp(1'b0, 1'b1, 1'b0, 32'd0);
                  state_reg <= RESP;
                end
              end
            endcase
          end
        end
        WAIT: begin
          // Completion is checked before the timeout so success wins a tie.
          if (wait_met) begin
            resp_reg  <= make_resp(1'b1, 1'b0, 1'b0,
                                   (op_reg == OP_REG_RD) ? reg_rdata : 32'd0);
            reg_req   <= 1'b0;
            state_reg <= RESP;
          end else if (cnt_reg == 16'(TIMEOUT)) begin
            resp_reg  <= make_resp(1'b0, 1'b1, 1'b1, 32'd0);
            reg_req   <= 1'b0;
            state_reg <= RESP;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        RESP: begin
          // The response stage lasts two cycles, which fixes the accept-to-response
          // latency at 3 cycles for commands that complete immediately.
          if (!resp_phase_reg) begin
            resp_phase_reg <= 1'b1;
          end else begin
            bus_rdata     <= resp_reg;
            bus_available <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_hub.sv
// Directed testbench for debug_hub (NUM_CORES=2, TIMEOUT=8). A behavioural
// core model drives hlt_state, step_done and the register port.
module tb_debug_hub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  bus_addr = 8'd3;
  logic        bus_start = 1'b0;
  logic [63:0] bus_wdata = '0;
  logic [63:0] bus_rdata;
  logic        bus_drive, bus_accepted, bus_available;
  logic [1:0]  hlt_req;
  logic [1:0]  hlt_state = 2'b11;
  logic [1:0]  step_req;
  logic [1:0]  step_done = 2'b00;
  logic        reg_req, reg_we, reg_ack = 1'b0;
  logic [7:0]  reg_core;
  logic [3:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata = '0;

  debug_hub #(.BUS_ADDR(8'd3), .DATA_W(64), .NUM_CORES(2), .REG_AW(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_start(bus_start),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_drive(bus_drive),
    .bus_accepted(bus_accepted), .bus_available(bus_available),
    .hlt_req(hlt_req), .hlt_state(hlt_state), .step_req(step_req),
    .step_done(step_done), .reg_req(reg_req), .reg_core(reg_core),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // core model configuration and state
  int          hlt_lag = 5;
  int          lag_cnt[2];
  int          ack_lag = 3;
  bit          ack_en = 1'b1;
  int          ack_cnt = 0;
  bit          step_other = 1'b0;
  logic [31:0] regs[2][16];

  // monitors
  bit          rq_seen;
  int          step0_cnt;
  int          avail_cnt;
  bit          stab_armed, stab_bad;
  logic [3:0]  stab_addr;
  logic        stab_we;
  logic [31:0] stab_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  // One clock cycle. The model reacts just after the edge, and outputs are
  // observed at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (hlt_req[i] !== hlt_state[i]) begin
        lag_cnt[i]++;
        if (lag_cnt[i] >= hlt_lag) begin
          hlt_state[i] = hlt_req[i];
          lag_cnt[i] = 0;
        end
      end else begin
        lag_cnt[i] = 0;
      end
    end
    step_done = step_other ? 2'b10 : 2'b00;
    if (reg_ack) begin
      reg_ack = 1'b0;
      ack_cnt = 0;
    end else if (reg_req === 1'b1 && ack_en) begin
      ack_cnt++;
      if (ack_cnt >= ack_lag) begin
        reg_ack = 1'b1;
        reg_rdata = regs[reg_core[0]][reg_addr];
        if (reg_we) regs[reg_core[0]][reg_addr] = reg_wdata;
      end
    end else begin
      ack_cnt = 0;
    end
    @(negedge clk);
    if (reg_req === 1'b1) rq_seen = 1'b1;
    if (step_req[0] === 1'b1) step0_cnt++;
    if (bus_available === 1'b1) avail_cnt++;
    if (reg_req === 1'b1) begin
      if (!stab_armed) begin
        stab_armed = 1'b1;
        stab_addr = reg_addr;
        stab_we = reg_we;
        stab_wdata = reg_wdata;
      end else if (reg_addr !== stab_addr || reg_we !== stab_we || reg_wdata !== stab_wdata) begin
        stab_bad = 1'b1;
      end
    end else begin
      stab_armed = 1'b0;
    end
  endtask

  task automatic send(input logic [63:0] cmd, output logic acc);
    rq_seen = 1'b0;
    step0_cnt = 0;
    stab_bad = 1'b0;
    bus_start = 1'b1;
    bus_wdata = cmd;
    tick();
    bus_start = 1'b0;
    acc = bus_accepted;
  endtask

  // Send a command and wait (bounded) for the response. poke_at > 0 raises
  // bus_start again on that wait cycle, which must not be accepted.
  task automatic run_cmd(input logic [63:0] cmd, input int poke_at, output logic acc,
                         output int lat, output logic [63:0] rd, output int extra_acc);
    send(cmd, acc);
    lat = -1;
    extra_acc = 0;
    for (int k = 1; k <= 60; k++) begin
      if (k == poke_at) begin
        bus_start = 1'b1;
        bus_wdata = 64'h0;
      end
      tick();
      bus_start = 1'b0;
      if (bus_accepted === 1'b1) extra_acc++;
      if (bus_available === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd = bus_rdata;
  endtask

  typedef struct {
    logic [63:0] cmd;
    logic [63:0] exp_rdata;
    int          exp_lat;
    logic [1:0]  exp_hlt;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [63:0] rd;
    logic        acc;
    int          lat, extra;

    for (int c = 0; c < 2; c++)
      for (int r = 0; r < 16; r++) regs[c][r] = 32'h0;

    // Both cores halted: single-shot commands with fixed latency.
    vecs[0] = '{64'h0000_0000_0000_0000, 64'h0000_0003_0000_0001, 3, 2'b11}; // STATUS
    vecs[1] = '{64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 4, 2'b11}; // HALT c0, already halted
    vecs[2] = '{64'h0000_0000_0000_0006, 64'h0000_0000_0000_0002, 3, 2'b11}; // bad opcode
    vecs[3] = '{64'h0000_0000_0000_0500, 64'h0000_0000_0000_0002, 3, 2'b11}; // core 5 STATUS
    vecs[4] = '{64'h0000_0000_0000_0502, 64'h0000_0000_0000_0002, 3, 2'b11}; // core 5 RESUME
    vecs[5] = '{64'h0000_0000_0000_00FF, 64'h0000_0000_0000_0002, 3, 2'b11}; // opcode 0xFF
    vecs[6] = '{64'h0000_0000_0000_0100, 64'h0000_0003_0000_0001, 3, 2'b11}; // STATUS via core 1

    // reset state
    tick(); tick();
    check("rst_hlt_req", 64'(hlt_req), 64'h3);
    check("rst_reg_req", 64'(reg_req), 64'h0);
    check("rst_step_req", 64'(step_req), 64'h0);
    check("rst_bus_rdata", bus_rdata, 64'h0);
    check("rst_accepted", 64'(bus_accepted), 64'h0);
    check("rst_available", 64'(bus_available), 64'h0);
    rst = 1'b0;
    bus_addr = 8'd4;
    #1 check("drive_other_addr", 64'(bus_drive), 64'h0);
    bus_addr = 8'd3;
    #1 check("drive_own_addr", 64'(bus_drive), 64'h1);
    tick();

    for (int v = 0; v < 7; v++) begin
      run_cmd(vecs[v].cmd, 0, acc, lat, rd, extra);
      check($sformatf("v%0d_accept", v), 64'(acc), 64'h1);
      check($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
      check($sformatf("v%0d_latency", v), 64'(lat), 64'(vecs[v].exp_lat));
      check($sformatf("v%0d_hlt_req", v), 64'(hlt_req), 64'(vecs[v].exp_hlt));
      check($sformatf("v%0d_reg_req_seen", v), 64'(rq_seen), 64'h0);
      tick();
    end

    // RESUME core 1: halted state drops 5 cycles later, extra strobe ignored.
    run_cmd(64'h0000_0000_0000_0102, 3, acc, lat, rd, extra);
    check("resume_rdata", rd, 64'h1);
    check("resume_latency", 64'(lat), 64'd8);
    check("resume_hlt_req", 64'(hlt_req), 64'h1);
    check("resume_no_accept_in_wait", 64'(extra), 64'h0);
    tick();

    run_cmd(64'h0000_0000_0000_0000, 0, acc, lat, rd, extra);
    check("status_c1_running", rd, 64'h0000_0001_0000_0001);

    run_cmd(64'h0000_0000_0007_0104, 0, acc, lat, rd, extra);
    check("rdrun_rdata", rd, 64'h2);
    check("rdrun_latency", 64'(lat), 64'd3);
    check("rdrun_reg_req_seen", 64'(rq_seen), 64'h0);

    run_cmd(64'h0000_0000_0000_0103, 0, acc, lat, rd, extra);
    check("steprun_rdata", rd, 64'h2);
    check("steprun_step_req", 64'(step0_cnt), 64'h0);
    tick();

    // REG_WR core 0 reg 7, ack 3 cycles after request.
    run_cmd(64'hDEAD_BEEF_0007_0005, 0, acc, lat, rd, extra);
    check("regwr_rdata", rd, 64'h1);
    check("regwr_latency", 64'(lat), 64'd6);
    check("regwr_stable", 64'(stab_bad), 64'h0);
    check("regwr_addr", 64'(stab_addr), 64'h7);
    check("regwr_we", 64'(stab_we), 64'h1);
    check("regwr_wdata", 64'(stab_wdata), 64'hDEAD_BEEF);
    check("regwr_reg_req_low", 64'(reg_req), 64'h0);
    tick();

    run_cmd(64'h0000_0000_0007_0004, 0, acc, lat, rd, extra);
    check("regrd_rdata", rd, 64'hDEAD_BEEF_0000_0001);
    check("regrd_latency", 64'(lat), 64'd6);
    check("regrd_we", 64'(stab_we), 64'h0);
    tick();

    // STEP core 0 with step_done withheld; only core 1 reports done.
    step_other = 1'b1;
    run_cmd(64'h0000_0000_0000_0003, 0, acc, lat, rd, extra);
    step_other = 1'b0;
    check("step_to_rdata", rd, 64'h6);
    check("step_to_latency", 64'(lat), 64'd12);
    check("step_to_pulse_cycles", 64'(step0_cnt), 64'h1);
    check("step_to_hlt_req", 64'(hlt_req), 64'h1);
    tick();

    // Reset in the middle of a REG_RD wait.
    ack_en = 1'b0;
    send(64'h0000_0000_0003_0004, acc);
    check("rstmid_accept", 64'(acc), 64'h1);
    tick(); tick(); tick();
    check("rstmid_reg_req_before", 64'(reg_req), 64'h1);
    rst = 1'b1;
    tick();
    check("rstmid_reg_req", 64'(reg_req), 64'h0);
    check("rstmid_hlt_req", 64'(hlt_req), 64'h3);
    rst = 1'b0;
    avail_cnt = 0;
    for (int k = 0; k < 20; k++) tick();
    check("rstmid_no_available", 64'(avail_cnt), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
